// File: rtl/bittiming_seq.sv
// rtl/bittiming_seq.sv - CAN bit-timing sequencer (SYNC/SEG1/SEG2, sample point, hard sync, resync)
//
// Counts time quanta through SYNC, SEG1 and SEG2. It samples rx at the sample point
// and pulses txpoint at the start of each bit. Recessive-to-dominant edges cause a
// hard sync or an SJW-limited resync. The SEG1 length lives in an external register.
// This block commands that register through ctrl and reads it back as tseg1mpl.
//
// Ports:
//   clock, reset          system clock, asynchronous active-high reset
//   prescale_en           time-quantum tick (single-clock pulse, at least 3 clocks apart)
//   rx                    bus level, 1 = recessive
//   hardsync_en           hard sync allowed
//   resync_en             resync allowed
//   tseg1, tseg2, sjw     nominal SEG1-1, SEG2-1, SJW-1
//   tseg1mpl              current SEG1 length - 1 from the external register
//   ctrl                  01 load tseg1, 10 load tseg1pcount, 11 load tseg1p1psjw, 00 hold
//   tseg1pcount           lengthened SEG1 - 1 for a small phase error
//   tseg1p1psjw           lengthened SEG1 - 1 for a phase error clipped to SJW
//   sample, smplbit       sample-point pulse and the captured bus level
//   txpoint               start-of-bit pulse
module bittiming_seq (
  input  logic       clock,
  input  logic       reset,
  input  logic       prescale_en,
  input  logic       rx,
  input  logic       hardsync_en,
  input  logic       resync_en,
  input  logic [2:0] tseg1,
  input  logic [2:0] tseg2,
  input  logic [1:0] sjw,
  input  logic [4:0] tseg1mpl,
  output logic [1:0] ctrl,
  output logic [4:0] tseg1pcount,
  output logic [4:0] tseg1p1psjw,
  output logic       sample,
  output logic       smplbit,
  output logic       txpoint
);

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_SEG1 = 2'd1,
    ST_SEG2 = 2'd2
  } state_t;

  localparam logic [1:0] CTRL_HOLD    = 2'b00;
  localparam logic [1:0] CTRL_TSEG1   = 2'b01;
  localparam logic [1:0] CTRL_PCOUNT  = 2'b10;
  localparam logic [1:0] CTRL_P1PSJW  = 2'b11;

  state_t     state;
  logic [3:0] cnt;
  logic [3:0] seg2len;
  logic       rx_prev;
  logic       resync_done;
  logic       load_pend;

  logic [4:0] cnt5;
  logic [4:0] sjw_p1;
  logic [4:0] seg1_end;
  logic [4:0] seg2_rem;
  logic       edge_det;
  logic       resync;

  assign cnt5     = {1'b0, cnt};
  assign sjw_p1   = {3'b000, sjw} + 5'd1;
  assign seg1_end = tseg1mpl + 5'd1;
  assign seg2_rem = {1'b0, seg2len} - cnt5;
  assign edge_det = rx_prev & ~rx;
  assign resync   = edge_det & resync_en & ~resync_done & smplbit;

  // cnt has already stepped past the edge quantum while ctrl=10 is presented,
  // so the phase error e is cnt-1 here; the new SEG1 length becomes nominal + e.
  assign tseg1pcount = {2'b00, tseg1} + cnt5 - 5'd1;
  assign tseg1p1psjw = {2'b00, tseg1} + 5'd1 + {3'b000, sjw};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_SYNC;
      cnt         <= 4'd0;
      seg2len     <= 4'd0;
      ctrl        <= CTRL_HOLD;
      sample      <= 1'b0;
      txpoint     <= 1'b0;
      smplbit     <= 1'b1;
      resync_done <= 1'b0;
      load_pend   <= 1'b1;
      rx_prev     <= 1'b1;
    end else begin
      ctrl    <= CTRL_HOLD;
      sample  <= 1'b0;
      txpoint <= 1'b0;

      // Restore the nominal SEG1 length once after reset.
      if (load_pend) begin
        ctrl      <= CTRL_TSEG1;
        load_pend <= 1'b0;
      end

      if (prescale_en) begin
        rx_prev <= rx;

        if (edge_det && hardsync_en) begin
          // Hard sync: the current quantum becomes SYNC, next tick is SEG1 tq 1.
          state       <= ST_SEG1;
          cnt         <= 4'd1;
          ctrl        <= CTRL_TSEG1;
          txpoint     <= 1'b1;
          resync_done <= 1'b1;
        end else if (resync) begin
          resync_done <= 1'b1;
          case (state)
            ST_SEG1: begin
              // Late edge: lengthen SEG1 by e or by SJW, whichever is smaller.
              // The end check is skipped; the new length is always >= cnt+1.
              ctrl <= (cnt5 <= sjw_p1) ? CTRL_PCOUNT : CTRL_P1PSJW;
              cnt  <= cnt + 4'd1;
            end
            ST_SEG2: begin
              if (seg2_rem <= sjw_p1) begin
                // Early edge within SJW of the bit end: start a new bit now.
                state   <= ST_SEG1;
                cnt     <= 4'd1;
                ctrl    <= CTRL_TSEG1;
                txpoint <= 1'b1;
              end else begin
                seg2len <= seg2len - sjw_p1[3:0];
                cnt     <= cnt + 4'd1;
              end
            end
            default: begin
              state <= ST_SEG1;
              cnt   <= 4'd1;
            end
          endcase
        end else begin
          case (state)
            ST_SYNC: begin
              state <= ST_SEG1;
              cnt   <= 4'd1;
            end
            ST_SEG1: begin
              if (cnt5 == seg1_end) begin
                state   <= ST_SEG2;
                cnt     <= 4'd1;
                sample  <= 1'b1;
                smplbit <= rx;
                seg2len <= {1'b0, tseg2} + 4'd1;
              end else begin
                cnt <= cnt + 4'd1;
              end
            end
            ST_SEG2: begin
              if (cnt == seg2len) begin
                state       <= ST_SYNC;
                cnt         <= 4'd0;
                txpoint     <= 1'b1;
                ctrl        <= CTRL_TSEG1;
                resync_done <= 1'b0;
              end else begin
                cnt <= cnt + 4'd1;
              end
            end
            default: begin
              state <= ST_SYNC;
              cnt   <= 4'd0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_bittiming_seq.sv
// tb/tb_bittiming_seq.sv - self-checking bench for bittiming_seq
module tb_bittiming_seq;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       prescale_en = 1'b0;
  logic       rx = 1'b1;
  logic       hardsync_en = 1'b0;
  logic       resync_en = 1'b0;
  logic [2:0] tseg1 = 3'd3;
  logic [2:0] tseg2 = 3'd2;
  logic [1:0] sjw = 2'd1;
  logic [4:0] tseg1mpl;
  logic [1:0] ctrl;
  logic [4:0] tseg1pcount;
  logic [4:0] tseg1p1psjw;
  logic       sample;
  logic       smplbit;
  logic       txpoint;

  bittiming_seq dut (
    .clock(clock), .reset(reset), .prescale_en(prescale_en), .rx(rx),
    .hardsync_en(hardsync_en), .resync_en(resync_en), .tseg1(tseg1), .tseg2(tseg2),
    .sjw(sjw), .tseg1mpl(tseg1mpl), .ctrl(ctrl), .tseg1pcount(tseg1pcount),
    .tseg1p1psjw(tseg1p1psjw), .sample(sample), .smplbit(smplbit), .txpoint(txpoint)
  );

  always #5 clock = ~clock;

  // External TSEG1 register: captures the commanded value, visible two clocks after ctrl.
  logic [4:0] ext_data;
  logic       ext_load;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      ext_data <= 5'd0;
      ext_load <= 1'b0;
      tseg1mpl <= 5'd0;
    end else begin
      ext_load <= (ctrl != 2'b00);
      case (ctrl)
        2'b01:   ext_data <= {2'b00, tseg1};
        2'b10:   ext_data <= tseg1pcount;
        2'b11:   ext_data <= tseg1p1psjw;
        default: ext_data <= ext_data;
      endcase
      if (ext_load) tseg1mpl <= ext_data;
    end
  end

  int errors = 0;
  int checks = 0;

  // Reference model: position of the tick within the bit and the current segment lengths.
  int m_done;
  int m_len1;
  int m_len2;
  bit m_rdone;
  bit m_bit;
  bit m_rxp;
  bit m_ldpend;
  logic [1:0] e_ctrl;
  bit e_smp;
  bit e_tx;
  int e_pc;

  // Observations from the most recent tick clock.
  logic [1:0] last_ctrl;
  logic [4:0] last_pc;
  logic [4:0] last_p1;
  logic       last_tx;
  int bit_ticks;
  int last_bitlen;
  int since_tx;
  int smp_dist;
  int n_tx;
  int n_smp;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_done   = 0;
    m_len1   = int'(tseg1) + 1;
    m_len2   = int'(tseg2) + 1;
    m_rdone  = 1'b0;
    m_bit    = 1'b1;
    m_rxp    = 1'b1;
    m_ldpend = 1'b1;
    bit_ticks = 0;
    since_tx  = 0;
  endtask

  task automatic model_tick(input logic r);
    bit ev;
    int t;
    int e;
    int r2;
    ev = m_rxp && !r;
    m_rxp = r;
    t = m_done + 1;
    e_ctrl = 2'b00;
    e_smp = 1'b0;
    e_tx = 1'b0;
    e_pc = 0;
    if (ev && hardsync_en) begin
      e_ctrl = 2'b01; e_tx = 1'b1; m_done = 1; m_len1 = int'(tseg1) + 1; m_rdone = 1'b1;
    end else if (ev && resync_en && !m_rdone && m_bit) begin
      m_rdone = 1'b1;
      if (t == 1) begin
        m_done = 1;
      end else if (t <= 1 + m_len1) begin
        e = t - 1;
        if (e <= int'(sjw) + 1) begin
          e_ctrl = 2'b10; e_pc = int'(tseg1) + e; m_len1 = int'(tseg1) + 1 + e;
        end else begin
          e_ctrl = 2'b11; e_pc = int'(tseg1) + 1 + int'(sjw); m_len1 = int'(tseg1) + 2 + int'(sjw);
        end
        m_done = t;
      end else begin
        r2 = t - 1 - m_len1;
        if (m_len2 - r2 <= int'(sjw) + 1) begin
          e_ctrl = 2'b01; e_tx = 1'b1; m_done = 1; m_len1 = int'(tseg1) + 1;
        end else begin
          m_len2 = m_len2 - (int'(sjw) + 1); m_done = t;
        end
      end
    end else begin
      if (t == 1 || t < 1 + m_len1) begin
        m_done = t;
      end else if (t == 1 + m_len1) begin
        e_smp = 1'b1; m_bit = r; m_len2 = int'(tseg2) + 1; m_done = t;
      end else if (t < 1 + m_len1 + m_len2) begin
        m_done = t;
      end else begin
        e_tx = 1'b1; e_ctrl = 2'b01; m_done = 0; m_len1 = int'(tseg1) + 1; m_rdone = 1'b0;
      end
    end
    if (m_ldpend && e_ctrl == 2'b00) e_ctrl = 2'b01;
    m_ldpend = 1'b0;
  endtask

  task automatic idle_clk();
    prescale_en = 1'b0;
    @(posedge clock);
    #1;
    chk("idle_ctrl", 8'(ctrl), m_ldpend ? 8'd1 : 8'd0);
    m_ldpend = 1'b0;
    chk("idle_sample", 8'(sample), 8'd0);
    chk("idle_txpoint", 8'(txpoint), 8'd0);
    chk("idle_smplbit", 8'(smplbit), 8'(m_bit));
  endtask

  // Two or three idle clocks, then one tick clock checked against the model.
  task automatic tick(input logic r);
    repeat (2 + $urandom_range(0, 1)) idle_clk();
    rx = r;
    prescale_en = 1'b1;
    @(posedge clock);
    #1;
    prescale_en = 1'b0;
    model_tick(r);
    chk("tick_ctrl", 8'(ctrl), 8'(e_ctrl));
    chk("tick_sample", 8'(sample), 8'(e_smp));
    chk("tick_txpoint", 8'(txpoint), 8'(e_tx));
    chk("tick_smplbit", 8'(smplbit), 8'(m_bit));
    if (e_ctrl == 2'b10) chk("tseg1pcount", 8'(tseg1pcount), 8'(e_pc));
    if (e_ctrl == 2'b11) chk("tseg1p1psjw", 8'(tseg1p1psjw), 8'(e_pc));
    last_ctrl = ctrl;
    last_pc   = tseg1pcount;
    last_p1   = tseg1p1psjw;
    last_tx   = txpoint;
    bit_ticks++;
    since_tx++;
    if (sample) begin
      smp_dist = since_tx;
      n_smp++;
    end
    if (txpoint) begin
      last_bitlen = bit_ticks;
      bit_ticks = 0;
      since_tx = 0;
      n_tx++;
    end
  endtask

  task automatic run_to_tx(input logic r);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick(r);
      found = last_tx;
    end
    chk("txpoint_timeout", 8'(found), 8'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_ctrl", 8'(ctrl), 8'd0);
    chk("rst_sample", 8'(sample), 8'd0);
    chk("rst_txpoint", 8'(txpoint), 8'd0);
    chk("rst_smplbit", 8'(smplbit), 8'd1);
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clock);
    #1;
    resync_en = 1'b1;
    do_reset();

    // Nominal bits: 1 + 4 + 3 = 8 tq.
    n_tx = 0;
    n_smp = 0;
    repeat (40) tick(1'b1);
    chk("t1_bitlen", 8'(last_bitlen), 8'd8);
    chk("t1_ntx", 8'(n_tx), 8'd5);
    chk("t1_nsmp", 8'(n_smp), 8'd5);
    chk("t1_tseg1mpl", 8'(tseg1mpl), 8'd3);

    // Late edge at SEG1 tq 1: lengthen by 1; a second edge in the bit is ignored.
    tick(1'b1);
    tick(1'b0);
    chk("t2_ctrl", 8'(last_ctrl), 8'd2);
    chk("t2_pcount", 8'(last_pc), 8'd4);
    tick(1'b1);
    tick(1'b0);
    chk("t2_second_edge", 8'(last_ctrl), 8'd0);
    run_to_tx(1'b1);
    chk("t2_bitlen", 8'(last_bitlen), 8'd9);

    // Late edge at SEG1 tq 3: clipped to SJW.
    tick(1'b1); tick(1'b1); tick(1'b1); tick(1'b0);
    chk("t3_ctrl", 8'(last_ctrl), 8'd3);
    chk("t3_p1psjw", 8'(last_p1), 8'd5);
    run_to_tx(1'b1);
    chk("t3_bitlen", 8'(last_bitlen), 8'd10);

    // Early edge at SEG2 tq 1: restart the bit.
    repeat (5) tick(1'b1);
    tick(1'b0);
    chk("t4_restart_tx", 8'(last_tx), 8'd1);
    chk("t4_bitlen", 8'(last_bitlen), 8'd6);
    run_to_tx(1'b1);

    // Long SEG2: early edge at SEG2 tq 2 shortens it to 6.
    tseg2 = 3'd7;
    repeat (6) tick(1'b1);
    tick(1'b0);
    chk("t4b_ctrl", 8'(last_ctrl), 8'd0);
    run_to_tx(1'b1);
    chk("t4b_bitlen", 8'(last_bitlen), 8'd11);
    tseg2 = 3'd2;

    // Hard sync in SEG2, then the sample point 4 ticks later.
    hardsync_en = 1'b1;
    repeat (5) tick(1'b1);
    tick(1'b0);
    chk("t5_ctrl", 8'(last_ctrl), 8'd1);
    chk("t5_tx", 8'(last_tx), 8'd1);
    hardsync_en = 1'b0;
    repeat (4) tick(1'b0);
    chk("t5_smp_dist", 8'(smp_dist), 8'd4);
    chk("t5_smplbit", 8'(smplbit), 8'd0);
    run_to_tx(1'b0);

    // Resync edge while smplbit=0: no correction.
    tick(1'b1);
    tick(1'b0);
    chk("t5b_ctrl", 8'(last_ctrl), 8'd0);
    run_to_tx(1'b0);
    chk("t5b_bitlen", 8'(last_bitlen), 8'd8);

    // Reset in SEG1 while a ctrl pulse is on the outputs and smplbit=0.
    tick(1'b1);
    tick(1'b1);
    hardsync_en = 1'b1;
    tick(1'b0);
    chk("t6_pre_ctrl", 8'(ctrl), 8'd1);
    hardsync_en = 1'b0;
    do_reset();
    repeat (5) tick(1'b1);
    chk("t6_smp_dist", 8'(smp_dist), 8'd5);

    // Randomized configuration and bus traffic against the model.
    for (int k = 0; k < 4; k++) begin
      tseg1 = 3'($urandom_range(0, 7));
      tseg2 = 3'($urandom_range(1, 7));
      sjw   = 2'($urandom_range(0, 3));
      hardsync_en = 1'b0;
      do_reset();
      for (int n = 0; n < 80; n++) begin
        hardsync_en = ($urandom_range(0, 15) == 0);
        resync_en   = ($urandom_range(0, 3) != 0);
        tick(($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
